// File: rtl/fp_cmp_pkg.sv
// Shared types for the floating-point min/max tracker.
// Holds only the tracker state encoding; width-dependent items are module parameters.
package fp_cmp_pkg;

    typedef enum logic [0:0] {
        StAccum,
        StDone
    } state_e;

endpackage

// File: rtl/fp_order_key.sv
// Maps a sign-exponent-magnitude sample onto an unsigned order key, so that
// an unsigned compare of two keys orders the samples numerically.
// Ports:
//   sample_i   W-bit sample {sign, exp[EXP_W], mag[MAG_W]}
//   key_o      (W+1)-bit unsigned order key
//   is_zero_o  sample has a zero magnitude (either sign, any exponent)
module fp_order_key #(
    parameter int unsigned EXP_W = 4,
    parameter int unsigned MAG_W = 8,
    localparam int unsigned W = 1 + EXP_W + MAG_W
) (
    input  logic [W-1:0] sample_i,
    output logic [W:0]   key_o,
    output logic         is_zero_o
);

    logic             sign;
    logic [EXP_W-1:0] exp_f;
    logic [MAG_W-1:0] mag;

    assign sign  = sample_i[W-1];
    assign exp_f = sample_i[MAG_W +: EXP_W];
    assign mag   = sample_i[MAG_W-1:0];

    // Negatives sit below zero (top bit 0, inverted so larger magnitude is smaller),
    // zero is exactly {1, 0...}, positives are offset by one above zero.
    always_comb begin
        is_zero_o = (mag == '0);
        if (is_zero_o) begin
            key_o = {1'b1, {W{1'b0}}};
        end else if (!sign) begin
            key_o = {2'b10, exp_f, mag} + (W + 1)'(1);
        end else begin
            key_o = {2'b00, ~exp_f, ~mag};
        end
    end

endmodule

// File: rtl/fp_minmax_tracker.sv
// Streaming min/max tracker over frames of sign-exponent-magnitude samples.
// Accepts samples on in_valid/in_ready, tracks the running extremes and their
// indices, and presents one result record per frame on out_valid/out_ready.
// A frame closes on in_last or when MAX_LEN samples have been accepted.
// Ports:
//   clk, reset_n               clock, async active-low reset
//   in_valid/in_ready          sample handshake (in_ready is state decode)
//   in_data, in_last           sample encoding and end-of-frame marker
//   out_valid/out_ready        result handshake
//   out_max/out_min            frame extremes (encodings)
//   out_max_idx/out_min_idx    0-based positions of the extremes
//   out_len                    samples in the frame
//   out_trunc                  frame was closed by the length limit
module fp_minmax_tracker
    import fp_cmp_pkg::*;
#(
    parameter int unsigned EXP_W   = 4,
    parameter int unsigned MAG_W   = 8,
    parameter int unsigned MAX_LEN = 256,
    localparam int unsigned W      = 1 + EXP_W + MAG_W,
    localparam int unsigned IDX_W  = $clog2(MAX_LEN),
    localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_max,
    output logic [W-1:0]     out_min,
    output logic [IDX_W-1:0] out_max_idx,
    output logic [IDX_W-1:0] out_min_idx,
    output logic [LEN_W-1:0] out_len,
    output logic             out_trunc
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [W:0]       max_key_q, max_key_d, min_key_q, min_key_d;
    logic [W-1:0]     max_q, max_d, min_q, min_d;
    logic [IDX_W-1:0] max_idx_q, max_idx_d, min_idx_q, min_idx_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             trunc_q, trunc_d;
    logic             valid_q, valid_d;

    logic [W:0]       in_key;
    logic             in_is_zero;
    logic             at_limit;

    fp_order_key #(
        .EXP_W(EXP_W),
        .MAG_W(MAG_W)
    ) u_in_key (
        .sample_i (in_data),
        .key_o    (in_key),
        .is_zero_o(in_is_zero)
    );

    assign in_ready = (state_q == StAccum);
    assign at_limit = (cnt_q == IDX_W'(MAX_LEN - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        max_key_d = max_key_q;
        min_key_d = min_key_q;
        max_d     = max_q;
        min_d     = min_q;
        max_idx_d = max_idx_q;
        min_idx_d = min_idx_q;
        len_d     = len_q;
        trunc_d   = trunc_q;
        valid_d   = valid_q;

        case (state_q)
            StAccum: begin
                if (in_valid) begin
                    // Strict compares keep the earliest index on ties.
                    if (cnt_q == '0 || in_key > max_key_q) begin
                        max_key_d = in_key;
                        max_d     = in_data;
                        max_idx_d = cnt_q;
                    end
                    if (cnt_q == '0 || in_key < min_key_q) begin
                        min_key_d = in_key;
                        min_d     = in_data;
                        min_idx_d = cnt_q;
                    end
                    if (in_last || at_limit) begin
                        cnt_d   = '0;
                        len_d   = LEN_W'(cnt_q) + LEN_W'(1);
                        trunc_d = at_limit && !in_last;
                        valid_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StAccum;
            cnt_q     <= '0;
            max_key_q <= '0;
            min_key_q <= '0;
            max_q     <= '0;
            min_q     <= '0;
            max_idx_q <= '0;
            min_idx_q <= '0;
            len_q     <= '0;
            trunc_q   <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            max_key_q <= max_key_d;
            min_key_q <= min_key_d;
            max_q     <= max_d;
            min_q     <= min_d;
            max_idx_q <= max_idx_d;
            min_idx_q <= min_idx_d;
            len_q     <= len_d;
            trunc_q   <= trunc_d;
            valid_q   <= valid_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_max     = max_q;
    assign out_min     = min_q;
    assign out_max_idx = max_idx_q;
    assign out_min_idx = min_idx_q;
    assign out_len     = len_q;
    assign out_trunc   = trunc_q;

    // All zeros must collapse to one key so +0 and -0 tie.
    ast_zero_key: assert property (@(posedge clk) disable iff (!reset_n)
        in_is_zero |-> (in_key == {1'b1, {W{1'b0}}}));

endmodule

// File: tb/tb_fp_minmax_tracker.sv
module tb_fp_minmax_tracker;

    localparam int unsigned EXP_W   = 4;
    localparam int unsigned MAG_W   = 8;
    // Small limit so truncation is exercised often.
    localparam int unsigned MAX_LEN = 4;
    localparam int unsigned W       = 1 + EXP_W + MAG_W;
    localparam int unsigned IDX_W   = $clog2(MAX_LEN);
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
    localparam int unsigned RW      = 1 + 2 * W + 2 * IDX_W + LEN_W + 1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_max;
    logic [W-1:0]     out_min;
    logic [IDX_W-1:0] out_max_idx;
    logic [IDX_W-1:0] out_min_idx;
    logic [LEN_W-1:0] out_len;
    logic             out_trunc;

    logic [RW-1:0]    obs;
    int               checks = 0;
    int               passes = 0;

    logic [W-1:0]     frm[MAX_LEN];
    int               frm_n;

    always #5 clk = ~clk;

    fp_minmax_tracker #(
        .EXP_W  (EXP_W),
        .MAG_W  (MAG_W),
        .MAX_LEN(MAX_LEN)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_max    (out_max),
        .out_min    (out_min),
        .out_max_idx(out_max_idx),
        .out_min_idx(out_min_idx),
        .out_len    (out_len),
        .out_trunc  (out_trunc)
    );

    assign obs = {out_valid, out_max, out_min, out_max_idx, out_min_idx, out_len, out_trunc};

    function automatic logic [RW-1:0] rec(input logic v, input logic [W-1:0] mx,
                                          input logic [W-1:0] mn, input int mxi, input int mni,
                                          input int len, input logic tr);
        return {v, mx, mn, IDX_W'(mxi), IDX_W'(mni), LEN_W'(len), tr};
    endfunction

    // Numeric value of a sample: (-1)^s * 0.M * 2^E, zero when mag is zero.
    function automatic real val(input logic [W-1:0] s);
        real v;
        int  e;
        e = int'(s[W-2:MAG_W]);
        if (s[MAG_W-1:0] == '0) return 0.0;
        v = real'(int'(s[MAG_W-1:0])) / real'(1 << MAG_W);
        for (int i = 0; i < e; i++) v = v * 2.0;
        return s[W-1] ? -v : v;
    endfunction

    // Expected record for frm[0..frm_n-1]: first occurrence of the largest and smallest value.
    function automatic logic [RW-1:0] model(input logic tr);
        int  bi, si;
        real bv, sv, v;
        bi = 0;
        si = 0;
        bv = val(frm[0]);
        sv = bv;
        for (int i = 1; i < frm_n; i++) begin
            v = val(frm[i]);
            if (v > bv) begin bv = v; bi = i; end
            if (v < sv) begin sv = v; si = i; end
        end
        return rec(1'b1, frm[bi], frm[si], bi, si, frm_n, tr);
    endfunction

    function automatic logic [W-1:0] gen_sample();
        logic [MAG_W-1:0] m;
        logic [EXP_W-1:0] e;
        logic             s;
        s = 1'($urandom);
        e = EXP_W'($urandom);
        m = MAG_W'($urandom);
        m[MAG_W-1] = 1'b1;
        if ($urandom_range(0, 4) == 0) m = '0;
        return {s, e, m};
    endfunction

    task automatic push(input logic [W-1:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            $display("FAIL push_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_last  = 1'($urandom);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (obs !== '0) $display("FAIL reset_outputs: got %h required 0", obs);
        else passes++;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({in_ready, obs} !== {1'b1, {RW{1'b0}}})
            $display("FAIL reset_release: got ready=%b rec=%h required ready=1 rec=0",
                     in_ready, obs);
        else passes++;
    endtask

    task automatic test_mixed_signs();
        logic [RW-1:0] e;
        push(13'h0380, 1'b0);
        push(13'h1380, 1'b0);
        push(13'h02C0, 1'b1);
        e = rec(1'b1, 13'h0380, 13'h1380, 0, 1, 3, 1'b0);
        checks++;
        if (obs !== e) $display("FAIL mixed_signs: got %h required %h", obs, e);
        else passes++;
        drain();
        checks++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL mixed_signs_release: got ready/valid=%b required 10",
                     {in_ready, out_valid});
        else passes++;
    endtask

    task automatic test_signed_zeros();
        logic [RW-1:0] e;
        push(13'h1000, 1'b0);
        push(13'h0000, 1'b0);
        push(13'h0500, 1'b1);
        e = rec(1'b1, 13'h1000, 13'h1000, 0, 0, 3, 1'b0);
        checks++;
        if (obs !== e) $display("FAIL signed_zeros: got %h required %h", obs, e);
        else passes++;
        drain();
    endtask

    task automatic test_all_negative();
        logic [RW-1:0] e;
        push(13'h1290, 1'b0);
        push(13'h1380, 1'b1);
        e = rec(1'b1, 13'h1290, 13'h1380, 0, 1, 2, 1'b0);
        checks++;
        if (obs !== e) $display("FAIL all_negative: got %h required %h", obs, e);
        else passes++;
        drain();
    endtask

    task automatic test_truncation();
        logic [RW-1:0] e;
        push(13'h02C0, 1'b0);
        push(13'h0380, 1'b0);
        push(13'h1290, 1'b0);
        push(13'h0000, 1'b0);
        e = rec(1'b1, 13'h0380, 13'h1290, 1, 2, 4, 1'b1);
        checks++;
        if (obs !== e) $display("FAIL truncation: got %h required %h", obs, e);
        else passes++;
        // Fifth sample is offered but must wait for the result handshake.
        in_valid = 1'b1;
        in_data  = 13'h0480;
        in_last  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({in_ready, obs} !== {1'b0, e})
                $display("FAIL truncation_hold: got ready=%b rec=%h required ready=0 rec=%h",
                         in_ready, obs, e);
            else passes++;
            @(posedge clk);
            #1;
        end
        drain();
        push(13'h0480, 1'b0);
        push(13'h02C0, 1'b1);
        e = rec(1'b1, 13'h0480, 13'h02C0, 0, 1, 2, 1'b0);
        checks++;
        if (obs !== e) $display("FAIL truncation_next: got %h required %h", obs, e);
        else passes++;
        drain();
    endtask

    task automatic test_backpressure();
        logic [RW-1:0] e;
        push(13'h0480, 1'b0);
        push(13'h1C80, 1'b1);
        e = rec(1'b1, 13'h0480, 13'h1C80, 0, 1, 2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            in_last  = 1'($urandom);
            checks++;
            if ({in_ready, obs} !== {1'b0, e})
                $display("FAIL backpressure_hold: got ready=%b rec=%h required ready=0 rec=%h",
                         in_ready, obs, e);
            else passes++;
            @(posedge clk);
            #1;
        end
        drain();
        checks++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL backpressure_release: got ready/valid=%b required 10",
                     {in_ready, out_valid});
        else passes++;
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        logic [RW-1:0] e;
        push(13'h02C0, 1'b0);
        push(13'h0380, 1'b0);
        reset_n = 1'b0;
        #2;
        checks++;
        if (obs !== '0) $display("FAIL reset_mid_frame: got %h required 0", obs);
        else passes++;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        push(13'h0200, 1'b1);
        e = rec(1'b1, 13'h0200, 13'h0200, 0, 0, 1, 1'b0);
        checks++;
        if (obs !== e) $display("FAIL reset_next_frame: got %h required %h", obs, e);
        else passes++;
        drain();
    endtask

    task automatic test_random();
        logic [RW-1:0] e;
        logic [W-1:0]  d;
        logic          l;
        int            len;
        frm_n = 0;
        for (int s = 0; s < 40; s++) begin
            len = $urandom_range(1, 7);
            for (int i = 0; i < len; i++) begin
                d = gen_sample();
                if (frm_n > 0 && $urandom_range(0, 4) == 0) d = frm[frm_n-1];
                l = (i == len - 1);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                push(d, l);
                frm[frm_n] = d;
                frm_n++;
                if (l || frm_n == MAX_LEN) begin
                    e = model(!l);
                    checks++;
                    if (obs !== e)
                        $display("FAIL random_frame %0d: got %h required %h", s, obs, e);
                    else passes++;
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                    drain();
                    checks++;
                    if ({in_ready, out_valid} !== 2'b10)
                        $display("FAIL random_release %0d: got ready/valid=%b required 10",
                                 s, {in_ready, out_valid});
                    else passes++;
                    frm_n = 0;
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_mixed_signs();
        test_signed_zeros();
        test_all_negative();
        test_truncation();
        test_backpressure();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
